iccm_port_arbiter: RTL and testbench
====================================

# iccm_port_arbiter

Owns the single ICCM SRAM port and shares it between two requesters: the TL-UL SRAM adapter (instruction fetch reads) and the UART boot-loader write stream from the ICCM programming controller. Programmer writes are buffered in a small FIFO. The arbiter drains in-flight fetch reads, commits the buffered writes, and holds the core in reset for the whole programming window. Sits between `tlul_sram_adapter`, `iccm_controller` and `instr_mem_top`.

## Interface

Parameters:
- `AW`, 12, word-address width.
- `DW`, 32, data width.
- `WFIFO_DEPTH`, 4, write-buffer entries (power of two, ≥2).
- `RST_HOLD`, 16, cycles `core_rst_o` stays high after the last write commits (≥1).
- `MAX_OUTST`, 2, maximum outstanding reads.

Ports:
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `prog_we_i` in 1: programmer write strobe, one word per cycle.
- `prog_addr_i` in AW: programmer word address.
- `prog_wdata_i` in DW: programmer write data.
- `prog_done_i` in 1: one-cycle pulse marking the end of the image.
- `bus_req_i` in 1: adapter read request.
- `bus_addr_i` in AW: adapter read address.
- `bus_gnt_o` out 1: read accepted this cycle.
- `bus_rvalid_o` out 1: read data valid.
- `bus_rdata_o` out DW: read data.
- `mem_req_o` out 1: SRAM request.
- `mem_we_o` out 1: SRAM write enable.
- `mem_addr_o` out AW: SRAM address.
- `mem_wdata_o` out DW: SRAM write data.
- `mem_rvalid_i` in 1: SRAM read valid; fixed 1-cycle latency.
- `mem_rdata_i` in DW: SRAM read data.
- `core_rst_o` out 1: active-high core reset hold.
- `prog_busy_o` out 1: state ≠ RUN.
- `wr_ovf_o` out 1: sticky flag, a programmer write was dropped.

## Operation

**Reset values.**
- State RUN; FIFO empty; outstanding count 0; `done_pend` 0; hold counter 0.
- `core_rst_o`, `prog_busy_o` and `wr_ovf_o` are 0.
- `mem_*` and `bus_*` outputs are 0.

**Write FIFO.**
- A `prog_we_i` high with the FIFO not full pushes {addr, data}. This happens in every state.
- A push while the FIFO is full drops the word and sets `wr_ovf_o`, which clears only on `reset`.
- The FIFO pops only in PROG. Push and pop in the same cycle are allowed; when full, the same-cycle pop frees the slot.

**Outstanding counter.**
- Increments on `bus_gnt_o`, decrements on `mem_rvalid_i`; both in one cycle leaves it unchanged.
- Width is clog2(MAX_OUTST+1).

**States.**
- **RUN**
  - `bus_gnt_o` = `bus_req_i` & ~`prog_we_i` & (outst < MAX_OUTST).
  - On grant: `mem_req_o`=1, `mem_we_o`=0, `mem_addr_o`=`bus_addr_i`.
  - `prog_we_i` → DRAIN.
- **DRAIN**
  - `bus_gnt_o`=0; `core_rst_o`=1.
  - Returning reads are still forwarded.
  - Registered outst==0 → PROG.
- **PROG**
  - When the FIFO is non-empty: `mem_req_o`=`mem_we_o`=1 with the head entry, pop.
  - `prog_done_i` sets `done_pend`.
  - `done_pend` (or `prog_done_i` this cycle) & FIFO empty after this cycle's pop → RELEASE; the hold counter loads RST_HOLD-1 and `done_pend` clears.
- **RELEASE**
  - `core_rst_o`=1; the counter decrements each cycle.
  - counter==0 → RUN.
  - `prog_we_i` → DRAIN; that word is pushed.
- `prog_done_i` outside PROG/DRAIN is ignored. In DRAIN it sets `done_pend`.
- `bus_rvalid_o`=`mem_rvalid_i` and `bus_rdata_o`=`mem_rdata_i`, passed through combinationally in all states.
- `mem_*` outputs are combinational from state, FIFO head and bus inputs.

## Timing

- Read path: grant and `mem_req_o` in cycle N; `bus_rvalid_o` in N+1.
- Programming entry: `prog_we_i` in cycle N (RUN) blocks the grant in N. DRAIN and `core_rst_o`=1 start in N+1.
- With no outstanding reads: PROG in N+2, and the first SRAM write in N+2.
- Write commit: one word per cycle in PROG. A word pushed in cycle M commits no earlier than M+1.
- Release: last pop in cycle L → RELEASE in L+1; `core_rst_o` falls and RUN resumes in L+1+RST_HOLD.
- Reset mid-operation: a `reset` in any state returns everything to reset values on the next edge. FIFO contents are discarded.

## Test plan

- **Read path.** RUN, `bus_req_i` on 0x010, then 0x011 back-to-back with no `mem_rvalid_i` → 2 grants, third request blocked. When `mem_rvalid_i` returns 0xDEADBEEF, `bus_rdata_o` = 0xDEADBEEF in the same cycle.
- **Programming sequence.** From RUN with 1 read outstanding, write 3 words (0x000←0x11, 0x001←0x22, 0x002←0x33) → DRAIN lasts until rvalid. The SRAM then sees the three writes in order on consecutive cycles, and `core_rst_o` is high throughout.
- **Release hold.** `prog_done_i` with the FIFO empty and RST_HOLD=16 → `core_rst_o` falls exactly 17 cycles after the last write commits. `bus_gnt_o` resumes the same cycle.
- **Overflow.** Hold DRAIN with outstanding reads, issue 5 writes at WFIFO_DEPTH=4 → the 5th is dropped, `wr_ovf_o`=1 and sticky. Only 4 writes reach the SRAM.
- **Re-program during RELEASE.** `prog_we_i` 3 cycles into RELEASE → DRAIN, then PROG. That word commits, and `core_rst_o` never drops.
- **Reset mid-programming.** `reset` in PROG with 2 words buffered → next cycle RUN, `core_rst_o`=0, FIFO empty, no further SRAM writes.

Source files
------------

// File: rtl/iccm_port_arbiter.sv
// Shares the single ICCM SRAM port between fetch reads and buffered boot-loader writes,
// holding the core in reset from the first programmer write until RST_HOLD cycles after the last commit.

module iccm_wfifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [W-1:0]                 wdata_i,
    output logic [W-1:0]                 rdata_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + PW'(1);
            if (pop_i)  rptr_q <= rptr_q + PW'(1);
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // Storage is left unreset; the pointers alone define which entries are live.
    always_ff @(posedge clock) begin
        if (push_i) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = cnt_q;
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
endmodule

module iccm_port_arbiter #(
    parameter int AW          = 12,
    parameter int DW          = 32,
    parameter int WFIFO_DEPTH = 4,
    parameter int RST_HOLD    = 16,
    parameter int MAX_OUTST   = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          prog_we_i,
    input  logic [AW-1:0] prog_addr_i,
    input  logic [DW-1:0] prog_wdata_i,
    input  logic          prog_done_i,
    input  logic          bus_req_i,
    input  logic [AW-1:0] bus_addr_i,
    output logic          bus_gnt_o,
    output logic          bus_rvalid_o,
    output logic [DW-1:0] bus_rdata_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic          mem_rvalid_i,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          core_rst_o,
    output logic          prog_busy_o,
    output logic          wr_ovf_o
);
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int HW = $clog2(RST_HOLD + 1);
    localparam int CW = $clog2(WFIFO_DEPTH + 1);

    typedef enum logic [1:0] {RUN, DRAIN, PROG, RELEASE} state_e;
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_ent_t;

    state_e        state_q, state_d;
    logic [OW-1:0] outst_q, outst_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          done_pend_q, done_pend_d;
    logic          wr_ovf_q;

    wr_ent_t       fifo_wdat, fifo_rdat;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_cnt, fifo_cnt_nxt;

    // A pop in the same cycle frees the slot, so a full FIFO can still accept that word.
    assign fifo_pop     = (state_q == PROG) && !fifo_empty;
    assign fifo_push    = prog_we_i && (!fifo_full || fifo_pop);
    assign fifo_cnt_nxt = fifo_cnt + CW'(fifo_push) - CW'(fifo_pop);
    assign fifo_wdat    = {prog_addr_i, prog_wdata_i};

    iccm_wfifo #(
        .W     ($bits(wr_ent_t)),
        .DEPTH (WFIFO_DEPTH)
    ) u_wfifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (fifo_wdat),
        .rdata_o (fifo_rdat),
        .count_o (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        done_pend_d = done_pend_q;
        hold_d      = hold_q;
        bus_gnt_o   = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (state_q)
            RUN: begin
                bus_gnt_o = bus_req_i && !prog_we_i && (outst_q < OW'(MAX_OUTST));
                if (bus_gnt_o) begin
                    mem_req_o  = 1'b1;
                    mem_addr_o = bus_addr_i;
                end
                if (prog_we_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (prog_done_i) done_pend_d = 1'b1;
                if (outst_q == '0) state_d = PROG;
            end
            PROG: begin
                if (fifo_pop) begin
                    mem_req_o   = 1'b1;
                    mem_we_o    = 1'b1;
                    mem_addr_o  = fifo_rdat.addr;
                    mem_wdata_o = fifo_rdat.data;
                end
                if (prog_done_i) done_pend_d = 1'b1;
                if ((done_pend_q || prog_done_i) && fifo_cnt_nxt == '0) begin
                    state_d     = RELEASE;
                    hold_d      = HW'(RST_HOLD - 1);
                    done_pend_d = 1'b0;
                end
            end
            RELEASE: begin
                hold_d = (hold_q == '0) ? '0 : hold_q - HW'(1);
                // A fresh write restarts programming without ever letting the core out of reset.
                if (prog_we_i)           state_d = DRAIN;
                else if (hold_q == '0)   state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    assign outst_d = outst_q + OW'(bus_gnt_o) - OW'(mem_rvalid_i);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= RUN;
            outst_q     <= '0;
            hold_q      <= '0;
            done_pend_q <= 1'b0;
            wr_ovf_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            outst_q     <= outst_d;
            hold_q      <= hold_d;
            done_pend_q <= done_pend_d;
            if (prog_we_i && fifo_full && !fifo_pop) wr_ovf_q <= 1'b1;
        end
    end

    assign bus_rvalid_o = mem_rvalid_i;
    assign bus_rdata_o  = mem_rdata_i;
    assign core_rst_o   = (state_q != RUN);
    assign prog_busy_o  = (state_q != RUN);
    assign wr_ovf_o     = wr_ovf_q;
endmodule

// File: tb/tb_iccm_port_arbiter.sv
// Directed scenarios plus randomized programming sessions against a queue/array reference of the port.
module tb_iccm_port_arbiter;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int RST_HOLD = 16;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic          clock, reset;
    logic          prog_we_i, prog_done_i, bus_req_i, mem_rvalid_i;
    logic [AW-1:0] prog_addr_i, bus_addr_i;
    logic [DW-1:0] prog_wdata_i, mem_rdata_i;
    logic          bus_gnt_o, bus_rvalid_o, mem_req_o, mem_we_o;
    logic          core_rst_o, prog_busy_o, wr_ovf_o;
    logic [DW-1:0] bus_rdata_o, mem_wdata_o;
    logic [AW-1:0] mem_addr_o;

    iccm_port_arbiter #(
        .AW(AW), .DW(DW), .WFIFO_DEPTH(4), .RST_HOLD(RST_HOLD), .MAX_OUTST(2)
    ) dut (
        .clock(clock), .reset(reset),
        .prog_we_i(prog_we_i), .prog_addr_i(prog_addr_i), .prog_wdata_i(prog_wdata_i),
        .prog_done_i(prog_done_i),
        .bus_req_i(bus_req_i), .bus_addr_i(bus_addr_i), .bus_gnt_o(bus_gnt_o),
        .bus_rvalid_o(bus_rvalid_o), .bus_rdata_o(bus_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .core_rst_o(core_rst_o), .prog_busy_o(prog_busy_o), .wr_ovf_o(wr_ovf_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc = 0, s_cyc = 0, last_commit = 0, done_cyc = 0, n_commits = 0;
    bit sram_auto = 1'b1;

    logic [DW-1:0] smem    [4096];
    logic [DW-1:0] ref_mem [4096];
    logic [AW-1:0] rd_q [$];
    wr_t           exp_wq [$];

    logic          s_gnt, s_rvalid, s_req, s_we, s_rst, s_busy, s_ovf;
    logic [DW-1:0] s_rdata, s_wdata;
    logic [AW-1:0] s_addr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: snapshot outputs mid-cycle, score SRAM traffic, then advance.
    task automatic tick();
        logic          prd;
        logic [DW-1:0] pdat;
        logic [AW-1:0] ra;
        wr_t           e;
        @(negedge clock);
        s_gnt = bus_gnt_o; s_rvalid = bus_rvalid_o; s_rdata = bus_rdata_o;
        s_req = mem_req_o; s_we = mem_we_o; s_addr = mem_addr_o; s_wdata = mem_wdata_o;
        s_rst = core_rst_o; s_busy = prog_busy_o; s_ovf = wr_ovf_o; s_cyc = cyc;
        prd = 1'b0; pdat = '0;
        if (!reset) begin
            if (prog_done_i) done_cyc = cyc;
            if (s_gnt) rd_q.push_back(bus_addr_i);
            if (s_rvalid && rd_q.size() > 0) begin
                ra = rd_q.pop_front();
                if (sram_auto) chk("rdata", s_rdata, ref_mem[ra]);
            end
            if (s_req && s_we) begin
                chk("wr_expected", exp_wq.size() > 0, 1'b1);
                if (exp_wq.size() > 0) begin
                    e = exp_wq.pop_front();
                    chk("wr_addr", s_addr, e.a);
                    chk("wr_data", s_wdata, e.d);
                    ref_mem[e.a] = e.d;
                end
                smem[s_addr] = s_wdata;
                n_commits++;
                last_commit = cyc;
            end else if (s_req) begin
                prd  = 1'b1;
                pdat = smem[s_addr];
            end
        end
        @(posedge clock);
        cyc++;
        #1;
        prog_we_i = 1'b0; prog_done_i = 1'b0; bus_req_i = 1'b0;
        if (sram_auto) begin
            mem_rvalid_i = prd;
            mem_rdata_i  = pdat;
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit acc);
        wr_t e;
        prog_we_i = 1'b1; prog_addr_i = a; prog_wdata_i = d;
        if (acc) begin
            e.a = a; e.d = d;
            exp_wq.push_back(e);
        end
    endtask

    // Core reset must fall RST_HOLD+1 cycles after the later of the last commit and the done pulse.
    task automatic wait_idle();
        int n;
        for (n = 0; n < 64; n++) begin
            tick();
            if (!s_rst) break;
        end
        chk("release_done", s_rst, 1'b0);
        chk("release_len", s_cyc,
            ((last_commit > done_cyc) ? last_commit : done_cyc) + 1 + RST_HOLD);
    endtask

    initial begin
        int c0, n, gap, idle;
        logic e;
        for (int i = 0; i < 4096; i++) begin smem[i] = '0; ref_mem[i] = '0; end
        reset = 1'b1; prog_we_i = 0; prog_done_i = 0; bus_req_i = 0; mem_rvalid_i = 0;
        prog_addr_i = '0; prog_wdata_i = '0; bus_addr_i = '0; mem_rdata_i = '0;
        tick(); tick();
        reset = 1'b0;

        // Reset values
        tick();
        chk("rst_core", s_rst, 1'b0); chk("rst_busy", s_busy, 1'b0); chk("rst_ovf", s_ovf, 1'b0);
        chk("rst_mem", {s_req, s_we, s_addr, s_wdata}, '0);
        chk("rst_bus", {s_gnt, s_rvalid, s_rdata}, '0);

        // Read path: two grants, third blocked until a read returns
        sram_auto = 1'b0;
        bus_req_i = 1; bus_addr_i = 12'h010; tick();
        chk("rd0_gnt", s_gnt, 1'b1); chk("rd0_mem", {s_req, s_we, s_addr}, {1'b1, 1'b0, 12'h010});
        bus_req_i = 1; bus_addr_i = 12'h011; tick();
        chk("rd1_gnt", s_gnt, 1'b1); chk("rd1_addr", s_addr, 12'h011);
        bus_req_i = 1; bus_addr_i = 12'h012; tick();
        chk("rd2_blocked", {s_gnt, s_req}, 2'b00);
        bus_req_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF; tick();
        chk("rd_rvalid", s_rvalid, 1'b1); chk("rd_rdata", s_rdata, 32'hDEADBEEF);
        chk("rd2_still_blocked", s_gnt, 1'b0);
        bus_req_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h0BADF00D; tick();
        chk("rd2_gnt_after_ret", s_gnt, 1'b1);
        mem_rvalid_i = 1; tick();
        mem_rvalid_i = 0;

        // Programming with one read outstanding, done pulsed during DRAIN
        bus_req_i = 1; bus_addr_i = 12'h020; tick();
        chk("pg_rd_gnt", s_gnt, 1'b1);
        wr(12'h000, 32'h11, 1); bus_req_i = 1; tick();
        chk("pg_we_blocks_gnt", s_gnt, 1'b0); chk("pg_run_rst", s_rst, 1'b0);
        wr(12'h001, 32'h22, 1); tick();
        chk("pg_drain_rst", {s_rst, s_busy}, 2'b11); chk("pg_drain_noreq", s_req, 1'b0);
        wr(12'h002, 32'h33, 1); mem_rvalid_i = 1; tick();
        chk("pg_drain2_noreq", s_req, 1'b0); chk("pg_drain2_rst", s_rst, 1'b1);
        mem_rvalid_i = 0; prog_done_i = 1; tick();
        chk("pg_drain3_noreq", s_req, 1'b0);
        tick(); chk("pg_w0", {s_req, s_we, s_addr, s_wdata}, {2'b11, 12'h000, 32'h11}); chk("pg_w0_rst", s_rst, 1'b1);
        tick(); chk("pg_w1", {s_req, s_we, s_addr, s_wdata}, {2'b11, 12'h001, 32'h22});
        tick(); chk("pg_w2", {s_req, s_we, s_addr, s_wdata}, {2'b11, 12'h002, 32'h33});
        c0 = last_commit;
        // Release hold: 16 more cycles in reset, then grants resume
        for (int i = 0; i < RST_HOLD; i++) begin
            bus_req_i = 1; bus_addr_i = 12'h030; tick();
            chk("hold_rst", s_rst, 1'b1); chk("hold_nogrant", s_gnt, 1'b0);
        end
        bus_req_i = 1; bus_addr_i = 12'h030; tick();
        chk("hold_fall", s_rst, 1'b0); chk("hold_gnt", s_gnt, 1'b1);
        chk("hold_len17", s_cyc - c0, RST_HOLD + 1);
        chk("pg_all_commit", exp_wq.size(), 0);
        mem_rvalid_i = 1; tick();
        mem_rvalid_i = 0;

        // Overflow: reads keep DRAIN busy while 5 writes arrive
        bus_req_i = 1; bus_addr_i = 12'h040; tick();
        bus_req_i = 1; bus_addr_i = 12'h041; tick();
        c0 = n_commits;
        for (int i = 0; i < 5; i++) begin
            wr(12'h100 + 12'(i), $urandom, i < 4); tick();
            chk("ovf_before", s_ovf, 1'b0);
            chk("ovf_noreq", s_req, 1'b0);
        end
        mem_rvalid_i = 1; tick();
        chk("ovf_set", s_ovf, 1'b1);
        mem_rvalid_i = 1; prog_done_i = 1; tick();
        mem_rvalid_i = 0;
        wait_idle();
        chk("ovf_commits", n_commits - c0, 4);
        chk("ovf_sticky", s_ovf, 1'b1);
        sram_auto = 1'b1;

        // Re-program during RELEASE
        wr(12'h200, 32'hA5A5_0001, 1); tick();
        prog_done_i = 1; tick(); chk("rp_drain", s_rst, 1'b1);
        tick(); chk("rp_w0", {s_we, s_addr}, {1'b1, 12'h200});
        for (int i = 0; i < 3; i++) begin tick(); chk("rp_rel", s_rst, 1'b1); end
        wr(12'h201, 32'hA5A5_0002, 1); tick(); chk("rp_rel_we", s_rst, 1'b1);
        tick(); chk("rp_redrain", {s_rst, s_req}, 2'b10);
        tick(); chk("rp_w1", {s_we, s_addr, s_wdata}, {1'b1, 12'h201, 32'hA5A5_0002});
        chk("rp_w1_rst", s_rst, 1'b1);
        prog_done_i = 1; tick(); chk("rp_done_rst", s_rst, 1'b1);
        wait_idle();

        // Reset while PROG holds two buffered words
        sram_auto = 1'b0;
        bus_req_i = 1; bus_addr_i = 12'h050; tick();
        wr(12'h300, 32'h1, 1); tick();
        wr(12'h301, 32'h2, 1); tick();
        wr(12'h302, 32'h3, 1); mem_rvalid_i = 1; tick();
        mem_rvalid_i = 0; tick();
        tick(); chk("mr_w0", {s_we, s_addr}, {1'b1, 12'h300});
        reset = 1'b1; tick(); reset = 1'b0;
        exp_wq.delete(); rd_q.delete();
        tick();
        chk("mr_core", {s_rst, s_busy}, 2'b00); chk("mr_ovf_clr", s_ovf, 1'b0); chk("mr_noreq", s_req, 1'b0);
        for (int i = 0; i < 5; i++) begin tick(); chk("mr_idle", s_req, 1'b0); end
        sram_auto = 1'b1;
        wr(12'h303, 32'h4, 1); tick();
        prog_done_i = 1; tick();
        wait_idle();
        chk("mr_fifo_empty", exp_wq.size(), 0);

        // Randomized sessions: reads while running, then a programming burst
        for (int s = 0; s < 24; s++) begin
            idle = $urandom_range(12, 4);
            for (int c = 0; c < idle; c++) begin
                bus_req_i = 1'($urandom_range(1, 0)); bus_addr_i = 12'($urandom_range(15, 0));
                e = bus_req_i && (rd_q.size() < 2);
                tick();
                chk("r_gnt", s_gnt, e); chk("r_rst", s_rst, 1'b0); chk("r_busy", s_busy, 1'b0);
            end
            n = $urandom_range(8, 1);
            for (int w = 0; w < n; w++) begin
                wr(12'($urandom_range(15, 0)), $urandom, 1);
                bus_req_i = 1'($urandom_range(1, 0));
                tick();
                chk("s_gnt", s_gnt, 1'b0); chk("s_rst", s_rst, w > 0);
                gap = $urandom_range(2, 0);
                for (int g = 0; g < gap; g++) begin
                    bus_req_i = 1'($urandom_range(1, 0)); tick();
                    chk("s_gap_gnt", s_gnt, 1'b0); chk("s_gap_rst", s_rst, 1'b1);
                end
            end
            prog_done_i = 1; tick();
            chk("s_done_rst", s_rst, 1'b1);
            wait_idle();
            chk("s_all_commit", exp_wq.size(), 0);
            chk("s_no_ovf", s_ovf, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
